// File: rtl/fsm_timer_pkg.sv
// Shared types and defaults for the multi-channel start/busy/done timer array.
package fsm_timer_pkg;

    // Counter width used when the instantiating block does not override it.
    localparam int CNT_W_DEF = 16;

    // Per-channel control state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Latched run mode.
    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

endpackage : fsm_timer_pkg

// File: rtl/fsm_timer_ch.sv
// One timer channel: IDLE/RUN FSM with a down-counter, latched period and
// mode, hold/abort handling and combinational done/overrun strobes.
module fsm_timer_ch
    import fsm_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cycles_i,
    input  logic             mode_i,
    input  logic             hold_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    state_e           state_q, state_d;
    mode_e            mode_q,  mode_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] len_q,   len_d;

    // A requested count of zero is treated as one so done always fires.
    logic [CNT_W-1:0] eff_cnt;
    logic             cnt_one;

    assign eff_cnt = (cycles_i == '0) ? CNT_W'(1) : cycles_i;
    assign cnt_one = (cnt_q == CNT_W'(1));
    assign busy_o  = (state_q == RUN);

    // Next-state, counter and strobe logic; abort > hold > count/done > start.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        done_o    = 1'b0;
        overrun_o = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with abort is dropped silently.
                if (start_i && !abort_i) begin
                    state_d = RUN;
                    cnt_d   = eff_cnt;
                    len_d   = eff_cnt;
                    mode_d  = mode_e'(mode_i);
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (hold_i) begin
                    overrun_o = start_i;
                end else if (!cnt_one) begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    overrun_o = start_i;
                end else begin
                    done_o = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        cnt_d     = len_q;
                        overrun_o = start_i;
                    end else if (start_i) begin
                        // Back-to-back one-shot: reload with no idle gap.
                        cnt_d  = eff_cnt;
                        len_d  = eff_cnt;
                        mode_d = mode_e'(mode_i);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= MODE_ONESHOT;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule : fsm_timer_ch

// File: rtl/fsm_timer_array.sv
// Array of independent programmable timer channels with a shared interrupt
// that is the OR of every channel's done strobe.
module fsm_timer_array
    import fsm_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH*CNT_W-1:0] cycles_i,
    input  logic [NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]       hold_i,
    input  logic [NUM_CH-1:0]       abort_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       overrun_o,
    output logic                    irq_o
);

    // One channel instance per timer, each with its own slice of cycles_i.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fsm_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .start_i   (start_i[c]),
            .cycles_i  (cycles_i[c*CNT_W +: CNT_W]),
            .mode_i    (mode_i[c]),
            .hold_i    (hold_i[c]),
            .abort_i   (abort_i[c]),
            .busy_o    (busy_o[c]),
            .done_o    (done_o[c]),
            .overrun_o (overrun_o[c])
        );
    end

    assign irq_o = |done_o;

endmodule : fsm_timer_array
